// File: rtl/pcie_cfg_ctrl.sv
// Interrupt arbiter, completion tracker and turnoff gate sitting on the PCIe core cfg_* interface.
// Latency: irq_req -> cfg_interrupt 2 cycles when idle; cfg_interrupt_rdy -> irq_ack 1 cycle.
// Backpressure: cfg_interrupt is held with a stable vector until cfg_interrupt_rdy; requests stay latched meanwhile.
module pcie_cfg_ctrl #(
  parameter int NCHAN           = 8,
  parameter int MAX_OUTSTANDING = 32,
  parameter int HOLDOFF         = 2,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1),
  localparam int IW = (NCHAN > 1) ? $clog2(NCHAN) : 1,
  localparam int GW = $clog2(HOLDOFF + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NCHAN-1:0] irq_req,
  output logic [NCHAN-1:0] irq_ack,
  output logic             cfg_interrupt,
  input  logic             cfg_interrupt_rdy,
  output logic [7:0]       cfg_interrupt_di,
  input  logic             cfg_interrupt_msienable,
  input  logic [2:0]       cfg_interrupt_mmenable,
  input  logic             np_req,
  input  logic             cpl_done,
  input  logic             cfg_to_turnoff,
  output logic             cfg_turnoff_ok,
  output logic             cfg_trn_pending,
  output logic [CW-1:0]    outstanding,
  output logic [1:0]       err_flags
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} irq_state_t;
  typedef enum logic {RUN, ACKED} to_state_t;

  irq_state_t       state, state_d;
  to_state_t        to_state, to_state_d;
  logic [NCHAN-1:0] pend, clr;
  logic [IW-1:0]    ptr, ptr_d, chan, chan_d, grant;
  logic [GW-1:0]    gap, gap_d;
  logic             int_d;
  logic [7:0]       di_d, mask;
  logic [CW-1:0]    cnt_d;
  logic [1:0]       err_d;
  logic             ok_d;
  logic [IW:0]      slot;

  // Sticky request latch; a new request in the clearing cycle keeps the bit set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pend <= '0;
    else       pend <= (pend & ~clr) | irq_req;
  end

  // Round-robin pick: first pending channel at or after the pointer, wrapping.
  always_comb begin
    grant = '0;
    slot  = '0;
    for (int k = NCHAN - 1; k >= 0; k--) begin
      slot = {1'b0, ptr} + (IW+1)'(k);
      if (slot >= (IW+1)'(NCHAN)) slot = slot - (IW+1)'(NCHAN);
      if (pend[slot[IW-1:0]]) grant = slot[IW-1:0];
    end
  end

  // Vector mask from the number of MSI vectors the host allocated.
  always_comb begin
    mask = 8'((9'd1 << cfg_interrupt_mmenable) - 9'd1);
  end

  // Interrupt FSM next-state and registered-output values.
  always_comb begin
    state_d = state;
    chan_d  = chan;
    di_d    = cfg_interrupt_di;
    int_d   = cfg_interrupt;
    ptr_d   = ptr;
    gap_d   = gap;
    clr     = '0;
    case (state)
      IDLE: begin
        int_d = 1'b0;
        if ((pend != '0) && cfg_interrupt_msienable && !cfg_to_turnoff) begin
          state_d = REQ;
          chan_d  = grant;
          di_d    = 8'(grant) & mask;
          int_d   = 1'b1;
        end
      end
      REQ: begin
        // Held until accepted even if MSI is disabled or turnoff arrives meanwhile.
        int_d = 1'b1;
        if (cfg_interrupt_rdy) begin
          int_d      = 1'b0;
          clr[chan]  = 1'b1;
          ptr_d      = (chan == IW'(NCHAN - 1)) ? '0 : chan + IW'(1);
          gap_d      = '0;
          state_d    = GAP;
        end
      end
      GAP: begin
        int_d = 1'b0;
        if (gap == GW'(HOLDOFF - 1)) state_d = IDLE;
        else                         gap_d   = gap + GW'(1);
      end
      default: begin
        state_d = IDLE;
        int_d   = 1'b0;
      end
    endcase
  end

  // Interrupt FSM state and handshake registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      chan             <= '0;
      ptr              <= '0;
      gap              <= '0;
      cfg_interrupt    <= 1'b0;
      cfg_interrupt_di <= '0;
      irq_ack          <= '0;
    end else begin
      state            <= state_d;
      chan             <= chan_d;
      ptr              <= ptr_d;
      gap              <= gap_d;
      cfg_interrupt    <= int_d;
      cfg_interrupt_di <= di_d;
      irq_ack          <= clr;
    end
  end

  // Outstanding-completion count with saturation/underflow error capture.
  always_comb begin
    cnt_d = outstanding;
    err_d = err_flags;
    case ({np_req, cpl_done})
      2'b10: begin
        if (outstanding == CW'(MAX_OUTSTANDING)) err_d[1] = 1'b1;
        else                                     cnt_d    = outstanding + CW'(1);
      end
      2'b01: begin
        if (outstanding == '0) err_d[0] = 1'b1;
        else                   cnt_d    = outstanding - CW'(1);
      end
      default: cnt_d = outstanding;
    endcase
  end

  // Counter, pending flag and sticky errors update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outstanding     <= '0;
      cfg_trn_pending <= 1'b0;
      err_flags       <= '0;
    end else begin
      outstanding     <= cnt_d;
      cfg_trn_pending <= (cnt_d != '0);
      err_flags       <= err_d;
    end
  end

  // Turnoff FSM: acknowledge once per turnoff request, only when fully quiet.
  always_comb begin
    to_state_d = to_state;
    ok_d       = 1'b0;
    case (to_state)
      RUN: begin
        if (cfg_to_turnoff && (outstanding == '0) && (state == IDLE) && !np_req) begin
          ok_d       = 1'b1;
          to_state_d = ACKED;
        end
      end
      ACKED: begin
        if (!cfg_to_turnoff) to_state_d = RUN;
      end
      default: to_state_d = RUN;
    endcase
  end

  // Turnoff state and acknowledge pulse register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_state       <= RUN;
      cfg_turnoff_ok <= 1'b0;
    end else begin
      to_state       <= to_state_d;
      cfg_turnoff_ok <= ok_d;
    end
  end

endmodule
